m_btb_predictor: RTL and testbench
==================================

Name: m_btb_predictor

Overview:
- Parametrised branch target buffer with per-entry 2-bit saturating direction counters and true-LRU replacement; the successor to the 2-entry predictor.
- The IF stage presents the fetch word address and receives the predicted target and a predict-taken flag in the same cycle, combinationally.
- The ID stage writes back resolved branch outcomes through the update port.
- Unlike the 2-entry predictor, it:
  - allocates only on taken branches;
  - predicts not-taken for weak or strong not-taken entries;
  - supports a synchronous flush.

Parameters:
ENTRIES, 4, number of BTB entries; power of two, >= 2
AW, 11, word-address width of PCs and targets
CW, 2, direction counter width (saturating, unsigned)

Ports:
w_clk  input  1  clock; all state updates on posedge
w_rst_n  input  1  asynchronous active-low reset
w_paddr  input  AW  fetch word address (r_pc[12:2] equivalent) for lookup
w_pr  output  AW  predicted target word address; 0 when w_pre=0
w_pre  output  1  1 = hit on a valid entry whose counter MSB is 1
w_hit  output  1  1 = lookup address matches a valid entry, regardless of counter
w_be  input  1  update strobe: a resolved branch is in ID this cycle
w_baddr  input  AW  word address of the resolved branch
w_btaken  input  1  resolved direction
w_btgt  input  AW  resolved taken-target word address
w_flush  input  1  synchronous invalidate-all
w_nvalid  output  log2(ENTRIES)+1  count of valid entries (registered state)

Behaviour:
- Reset and clock:
  - Single clock w_clk.
  - Reset asynchronous, active-low (w_rst_n). While low:
    - all valid bits = 0;
    - counters = 0;
    - tags and targets = 0;
    - age[i] = i.
  - Therefore w_pre=0, w_hit=0, w_pr=0, w_nvalid=0 during and after reset.
- Per-entry state: valid, tag[AW], target[AW], ctr[CW], age[log2 ENTRIES].
  - Ages always form a permutation of 0..ENTRIES-1; 0 = MRU.
- Lookup (combinational, zero latency):
  - hit = a valid entry has tag == w_paddr.
  - Allocation policy guarantees at most one match.
  - w_pre = hit && ctr[CW-1].
  - w_pr = target of the hit entry if w_pre, else 0.
  - Lookup does not modify LRU.
- Update (posedge, when w_be=1 and w_flush=0):
  - Update hit (valid tag == w_baddr):
    - taken: ctr = min(ctr+1, 2^CW-1) and target <= w_btgt;
    - not taken: ctr = max(ctr-1, 0) and target unchanged;
    - entry becomes MRU.
  - Update miss, taken: allocate a victim.
    - Victim = lowest-index invalid entry; if none, the entry with age ENTRIES-1.
    - Write valid=1, tag=w_baddr, target=w_btgt, ctr = 2^(CW-1) (weakly taken).
    - Victim becomes MRU.
  - Update miss, not taken: no state change.
- LRU touch of entry k: age[k] <= 0; every entry j with age[j] < age[k] gets age[j]+1; others unchanged.
- Flush:
  - w_flush=1 at posedge clears all valid bits and resets ages to index order.
  - Flush takes priority over a simultaneous w_be; the update is dropped.
- Same-cycle lookup and update of the same address: lookup returns pre-update state. There is no bypass; the new state is visible the next cycle.
- w_nvalid: registered popcount of the valid bits; saturates naturally at ENTRIES.
- Reset asserted mid-operation: immediate clear of all state, independent of clock.
- Outputs are X-free whenever w_paddr is known.
- Widths: tags compared at full AW; no aliasing. Counter arithmetic saturates and never wraps.

Test Plan:
- Reset, then lookup 0x010 -> w_hit=0, w_pre=0, w_pr=0, w_nvalid=0. Assert w_rst_n low mid-run after 3 allocations -> all outputs 0 immediately.
- Allocation and counter training (CW=2):
  - update taken, baddr 0x010, btgt 0x040 -> next cycle lookup 0x010: w_hit=1, w_pre=1, w_pr=0x040, w_nvalid=1;
  - two not-taken updates to 0x010 -> ctr 2→1→0: w_hit=1, w_pre=0, w_pr=0;
  - two taken updates -> ctr 2, w_pre=1;
  - three more taken updates -> ctr saturates at 3 (one not-taken then still predicts taken).
- Not-taken miss: update not-taken, baddr 0x020 -> w_hit=0, w_nvalid unchanged.
- LRU (ENTRIES=4):
  - allocate A=0x10, B=0x20, C=0x30, D=0x40 (targets 0x100..0x400);
  - touch A with a taken update;
  - allocate E=0x50 -> B evicted: lookup 0x20 misses, 0x10 and 0x50 hit, w_nvalid=4;
  - allocate F=0x60 -> C evicted.
- Retarget: taken update on hit 0x10 with btgt 0x1F0 -> lookup 0x10 returns w_pr=0x1F0.
- Simultaneity:
  - in the same cycle as allocating 0x70, lookup 0x70 -> w_hit=0; next cycle w_hit=1;
  - w_flush=1 together with w_be taken to 0x80 -> next cycle all lookups miss and w_nvalid=0.

Source files
------------

// File: rtl/m_btb_predictor_if.sv
// Lookup/update bus between the fetch/decode stages and the branch target buffer.
// Signal names match the original flat port list so wiring stays recognisable.
interface m_btb_predictor_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned NW = 3
);
    logic [AW-1:0] w_paddr;
    logic [AW-1:0] w_pr;
    logic          w_pre;
    logic          w_hit;
    logic          w_be;
    logic [AW-1:0] w_baddr;
    logic          w_btaken;
    logic [AW-1:0] w_btgt;
    logic          w_flush;
    logic [NW-1:0] w_nvalid;

    modport master (
        output w_paddr, w_be, w_baddr, w_btaken, w_btgt, w_flush,
        input  w_pr, w_pre, w_hit, w_nvalid
    );

    modport slave (
        input  w_paddr, w_be, w_baddr, w_btaken, w_btgt, w_flush,
        output w_pr, w_pre, w_hit, w_nvalid
    );
endinterface

// File: rtl/m_btb_predictor.sv
// Branch target buffer: per-entry saturating direction counters, true-LRU ages,
// allocate-on-taken, synchronous flush. Lookup is combinational and never bypasses updates.
module m_btb_predictor #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned AW      = 11,
    parameter int unsigned CW      = 2
) (
    input  logic                w_clk,
    input  logic                w_rst_n,
    m_btb_predictor_if.slave    bus
);
    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned NW = IW + 1;
    localparam logic [CW-1:0] CTR_MAX  = '1;
    localparam logic [CW-1:0] CTR_WEAK = CW'(1) << (CW - 1);

    logic [ENTRIES-1:0] valid, valid_n;
    logic [AW-1:0]      tag    [ENTRIES];
    logic [AW-1:0]      tag_n  [ENTRIES];
    logic [AW-1:0]      tgt    [ENTRIES];
    logic [AW-1:0]      tgt_n  [ENTRIES];
    logic [CW-1:0]      ctr    [ENTRIES];
    logic [CW-1:0]      ctr_n  [ENTRIES];
    logic [IW-1:0]      age    [ENTRIES];
    logic [IW-1:0]      age_n  [ENTRIES];
    logic [NW-1:0]      nvalid, nvalid_n;

    logic          look_hit;
    logic [IW-1:0] look_idx;
    logic          upd_hit;
    logic [IW-1:0] upd_idx;
    logic [IW-1:0] victim;
    logic          have_free;
    logic          do_touch;
    logic [IW-1:0] touch_idx;

    // Fetch-side lookup
    always_comb begin
        look_hit = 1'b0;
        look_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tag[i] == bus.w_paddr) begin
                look_hit = 1'b1;
                look_idx = IW'(i);
            end
        end
    end

    assign bus.w_hit    = look_hit;
    assign bus.w_pre    = look_hit && ctr[look_idx][CW-1];
    assign bus.w_pr     = bus.w_pre ? tgt[look_idx] : '0;
    assign bus.w_nvalid = nvalid;

    // Update-side match and victim choice (lowest free slot beats the LRU slot)
    always_comb begin
        upd_hit   = 1'b0;
        upd_idx   = '0;
        victim    = '0;
        have_free = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tag[i] == bus.w_baddr) begin
                upd_hit = 1'b1;
                upd_idx = IW'(i);
            end
            if (age[i] == IW'(ENTRIES - 1)) begin
                victim = IW'(i);
            end
        end
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!valid[i] && !have_free) begin
                victim    = IW'(i);
                have_free = 1'b1;
            end
        end
    end

    always_comb begin
        valid_n   = valid;
        tag_n     = tag;
        tgt_n     = tgt;
        ctr_n     = ctr;
        age_n     = age;
        do_touch  = 1'b0;
        touch_idx = '0;
        nvalid_n  = '0;

        if (bus.w_flush) begin
            valid_n = '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                age_n[i] = IW'(i);
            end
        end else if (bus.w_be) begin
            if (upd_hit) begin
                do_touch  = 1'b1;
                touch_idx = upd_idx;
                if (bus.w_btaken) begin
                    tgt_n[upd_idx] = bus.w_btgt;
                    if (ctr[upd_idx] != CTR_MAX) begin
                        ctr_n[upd_idx] = ctr[upd_idx] + CW'(1);
                    end
                end else if (ctr[upd_idx] != '0) begin
                    ctr_n[upd_idx] = ctr[upd_idx] - CW'(1);
                end
            end else if (bus.w_btaken) begin
                do_touch        = 1'b1;
                touch_idx       = victim;
                valid_n[victim] = 1'b1;
                tag_n[victim]   = bus.w_baddr;
                tgt_n[victim]   = bus.w_btgt;
                ctr_n[victim]   = CTR_WEAK;
            end
        end

        // Ages stay a permutation: only entries younger than the touched one shift
        if (do_touch) begin
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                if (IW'(j) == touch_idx) begin
                    age_n[j] = '0;
                end else if (age[j] < age[touch_idx]) begin
                    age_n[j] = age[j] + IW'(1);
                end
            end
        end

        for (int unsigned i = 0; i < ENTRIES; i++) begin
            nvalid_n = nvalid_n + NW'(valid_n[i]);
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            valid  <= '0;
            nvalid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag[i] <= '0;
                tgt[i] <= '0;
                ctr[i] <= '0;
                age[i] <= IW'(i);
            end
        end else begin
            valid  <= valid_n;
            tag    <= tag_n;
            tgt    <= tgt_n;
            ctr    <= ctr_n;
            age    <= age_n;
            nvalid <= nvalid_n;
        end
    end
endmodule

// File: tb/tb_m_btb_predictor.sv
// Directed bench for m_btb_predictor (ENTRIES=4, AW=11, CW=2).
// Expected vectors are packed as {hit, pre, pr[10:0], nvalid[2:0]}.
module tb_m_btb_predictor;
    localparam int unsigned AW = 11;
    localparam int unsigned NW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    m_btb_predictor_if #(.AW(AW), .NW(NW)) bus ();

    m_btb_predictor #(.ENTRIES(4), .AW(AW), .CW(2)) dut (
        .w_clk   (clk),
        .w_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic look(input logic [AW-1:0] a);
        bus.w_paddr = a;
        #1;
    endtask

    task automatic upd(input logic [AW-1:0] a, input logic t, input logic [AW-1:0] g);
        @(negedge clk);
        bus.w_be = 1'b1; bus.w_baddr = a; bus.w_btaken = t; bus.w_btgt = g;
        @(posedge clk);
        #1 bus.w_be = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        bus.w_flush = 1'b1;
        @(posedge clk);
        #1 bus.w_flush = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        bus.w_be = 1'b0; bus.w_flush = 1'b0; bus.w_btaken = 1'b0;
        bus.w_baddr = '0; bus.w_btgt = '0;
        look(11'h010);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== 16'h0) begin
            $display("FAIL reset_state got=%h want=%h", got, 16'h0); bad++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        look(11'h010);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== 16'h0) begin
            $display("FAIL post_reset got=%h want=%h", got, 16'h0); bad++;
        end
    endtask

    task automatic test_training();
        logic        tk [11] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
        logic [15:0] ex [11];
        logic [15:0] got;
        ex[0]  = {1'b1, 1'b1, 11'h040, 3'd1};
        ex[1]  = {1'b1, 1'b0, 11'h000, 3'd1};
        ex[2]  = {1'b1, 1'b0, 11'h000, 3'd1};
        ex[3]  = {1'b1, 1'b0, 11'h000, 3'd1};   // saturated at 0
        ex[4]  = {1'b1, 1'b0, 11'h000, 3'd1};   // 0 -> 1, still not taken
        ex[5]  = {1'b1, 1'b1, 11'h040, 3'd1};
        ex[6]  = {1'b1, 1'b1, 11'h040, 3'd1};
        ex[7]  = {1'b1, 1'b1, 11'h040, 3'd1};
        ex[8]  = {1'b1, 1'b1, 11'h040, 3'd1};
        ex[9]  = {1'b1, 1'b1, 11'h040, 3'd1};   // 3 -> 2
        ex[10] = {1'b1, 1'b0, 11'h000, 3'd1};   // 2 -> 1
        for (int i = 0; i < 11; i++) begin
            upd(11'h010, tk[i], 11'h040);
            look(11'h010);
            got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
            total++;
            if (got !== ex[i]) begin
                $display("FAIL training step %0d got=%h want=%h", i, got, ex[i]); bad++;
            end
        end
    endtask

    task automatic test_nt_miss();
        logic [15:0] got;
        upd(11'h020, 1'b0, 11'h123);
        look(11'h020);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== {1'b0, 1'b0, 11'h000, 3'd1}) begin
            $display("FAIL nt_miss got=%h want=%h", got, {1'b0, 1'b0, 11'h000, 3'd1}); bad++;
        end
    endtask

    task automatic test_flush();
        logic [15:0] got;
        do_flush();
        look(11'h010);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== 16'h0) begin
            $display("FAIL flush got=%h want=%h", got, 16'h0); bad++;
        end
    endtask

    task automatic test_lru();
        logic [AW-1:0] la [6] = '{11'h020, 11'h010, 11'h050, 11'h030, 11'h060, 11'h040};
        logic [15:0]   ex [6];
        logic [15:0]   got;
        ex[0] = {1'b0, 1'b0, 11'h000, 3'd4};
        ex[1] = {1'b1, 1'b1, 11'h100, 3'd4};
        ex[2] = {1'b1, 1'b1, 11'h500, 3'd4};
        ex[3] = {1'b0, 1'b0, 11'h000, 3'd4};
        ex[4] = {1'b1, 1'b1, 11'h600, 3'd4};
        ex[5] = {1'b1, 1'b1, 11'h400, 3'd4};
        for (int i = 1; i <= 4; i++) begin
            upd(AW'(16 * i), 1'b1, AW'(256 * i));
        end
        upd(11'h010, 1'b1, 11'h100);
        upd(11'h050, 1'b1, 11'h500);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) upd(11'h060, 1'b1, 11'h600);
            look(la[i]);
            got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
            total++;
            if (got !== ex[i]) begin
                $display("FAIL lru addr=%h got=%h want=%h", la[i], got, ex[i]); bad++;
            end
        end
    endtask

    task automatic test_retarget();
        logic [15:0] got;
        upd(11'h010, 1'b1, 11'h1F0);
        look(11'h010);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== {1'b1, 1'b1, 11'h1F0, 3'd4}) begin
            $display("FAIL retarget got=%h want=%h", got, {1'b1, 1'b1, 11'h1F0, 3'd4}); bad++;
        end
    endtask

    task automatic test_same_cycle();
        logic [15:0] got;
        @(negedge clk);
        bus.w_be = 1'b1; bus.w_baddr = 11'h070; bus.w_btaken = 1'b1; bus.w_btgt = 11'h700;
        look(11'h070);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== {1'b0, 1'b0, 11'h000, 3'd4}) begin
            $display("FAIL same_cycle_pre got=%h want=%h", got, {1'b0, 1'b0, 11'h000, 3'd4}); bad++;
        end
        @(posedge clk);
        #1 bus.w_be = 1'b0;
        look(11'h070);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== {1'b1, 1'b1, 11'h700, 3'd4}) begin
            $display("FAIL same_cycle_post got=%h want=%h", got, {1'b1, 1'b1, 11'h700, 3'd4}); bad++;
        end
    endtask

    task automatic test_flush_priority();
        logic [AW-1:0] la [3] = '{11'h080, 11'h010, 11'h070};
        logic [15:0]   got;
        @(negedge clk);
        bus.w_flush = 1'b1;
        bus.w_be = 1'b1; bus.w_baddr = 11'h080; bus.w_btaken = 1'b1; bus.w_btgt = 11'h7F0;
        @(posedge clk);
        #1 begin bus.w_flush = 1'b0; bus.w_be = 1'b0; end
        for (int i = 0; i < 3; i++) begin
            look(la[i]);
            got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
            total++;
            if (got !== 16'h0) begin
                $display("FAIL flush_priority addr=%h got=%h want=%h", la[i], got, 16'h0); bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        upd(11'h011, 1'b1, 11'h111);
        upd(11'h022, 1'b1, 11'h222);
        upd(11'h033, 1'b1, 11'h333);
        look(11'h022);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== {1'b1, 1'b1, 11'h222, 3'd3}) begin
            $display("FAIL pre_reset got=%h want=%h", got, {1'b1, 1'b1, 11'h222, 3'd3}); bad++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        look(11'h022);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== 16'h0) begin
            $display("FAIL async_reset got=%h want=%h", got, 16'h0); bad++;
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        look(11'h011);
        got = {bus.w_hit, bus.w_pre, bus.w_pr, bus.w_nvalid};
        total++;
        if (got !== 16'h0) begin
            $display("FAIL after_reset got=%h want=%h", got, 16'h0); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_nt_miss();
        test_flush();
        test_lru();
        test_retarget();
        test_same_cycle();
        test_flush_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
